// File: rtl/fifo_word_serializer_if.sv
// Handshake bundle between sync_fifo read side, the word serializer and the
// downstream beat consumer.
// master: serializer side (drives FIFO read strobe and output beat stream).
// slave : environment side (FIFO status/data and downstream ready).
interface fifo_word_serializer_if #(
    parameter int DWIDTH = 16,
    parameter int OWIDTH = 4
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [OWIDTH-1:0] m_data;
    logic              m_last;
    logic              busy;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, busy
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains DWIDTH-bit words from sync_fifo and emits them as DWIDTH/OWIDTH
// beats of OWIDTH bits on a valid/ready stream. A one-word prefetch register
// covers the FIFO read latency so consecutive words stream without gaps.
// Build option: define SER_LSB_FIRST_EN to emit beats LSB first
// (default is MSB first).
module fifo_word_serializer #(
    parameter int DWIDTH = 16,
    parameter int OWIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    fifo_word_serializer_if.master  bus
);
    localparam int RATIO = DWIDTH / OWIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic              pend;
    logic              pf_valid;
    logic [DWIDTH-1:0] pf_data;
    logic              sh_valid;
    logic [DWIDTH-1:0] sh;
    logic [CW-1:0]     cnt;

    logic beat_acc;
    logic beat_last;
    logic pf_load;
    logic rd_en;

    // Handshake decode; the read strobe is gated by reset so the FIFO is
    // never touched while rstn is low.
    always_comb begin
        beat_last = sh_valid & (cnt == LAST_CNT);
        beat_acc  = sh_valid & bus.m_ready;
        pf_load   = pf_valid & (~sh_valid | (beat_acc & beat_last));
        rd_en     = rstn & ~bus.fifo_empty & ~pend & (~pf_valid | pf_load);
    end

    // Read-pending flag and prefetch register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend     <= 1'b0;
            pf_valid <= 1'b0;
            pf_data  <= '0;
        end else begin
            pend <= rd_en;
            if (pend) begin
                pf_data  <= bus.fifo_dout;
                pf_valid <= 1'b1;
            end else if (pf_load) begin
                pf_valid <= 1'b0;
            end
        end
    end

    // Shift register and beat counter; a last-beat accept that coincides
    // with a prefetched word reloads immediately, giving gapless beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh       <= '0;
            sh_valid <= 1'b0;
            cnt      <= '0;
        end else if (pf_load) begin
            sh       <= pf_data;
            sh_valid <= 1'b1;
            cnt      <= '0;
        end else if (beat_acc) begin
            if (!beat_last) begin
`ifdef SER_LSB_FIRST_EN
                sh <= sh >> OWIDTH;
`else
                sh <= sh << OWIDTH;
`endif
                cnt <= cnt + 1'b1;
            end else begin
                sh_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = sh_valid;
    assign bus.m_last     = beat_last;
    assign bus.busy       = pend | pf_valid | sh_valid;
`ifdef SER_LSB_FIRST_EN
    assign bus.m_data     = sh[OWIDTH-1:0];
`else
    assign bus.m_data     = sh[DWIDTH-1 -: OWIDTH];
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer (DWIDTH=16, OWIDTH=4) with a
// behavioural sync_fifo read-side model.
module tb_fifo_word_serializer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rdy = 1'b0;
    logic fe = 1'b1;
    logic [15:0] fd = '0;
    logic [15:0] fq[$];
    int unsigned rd_count = 0;
    int unsigned rd_while_empty = 0;
    int checks = 0;
    int errors = 0;

    fifo_word_serializer_if #(.DWIDTH(16), .OWIDTH(4)) bus ();

    fifo_word_serializer #(.DWIDTH(16), .OWIDTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    assign bus.fifo_empty = fe;
    assign bus.fifo_dout  = fd;
    assign bus.m_ready    = rdy;

    always #5 clk = ~clk;

    // sync_fifo read side: dout valid the cycle after an accepted read,
    // empty reflects queue occupancy after each edge.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_count++;
            if (fe) rd_while_empty++;
            if (fq.size() > 0) fd <= fq.pop_front();
        end
        fe <= (fq.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] beat(input logic [15:0] w, input int i);
        logic [15:0] v;
        v = w;
`ifdef SER_LSB_FIRST_EN
        return v[4*i +: 4];
`else
        return v[15-4*i -: 4];
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && !bus.m_valid; k++) @(negedge clk);
        chk(tag, bus.m_valid, 1'b1);
    endtask

    task automatic check_word(input string tag, input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, bus.m_valid, 1'b1);
            chk({tag, "_data"}, bus.m_data, beat(w, i));
            chk({tag, "_last"}, bus.m_last, (i == 3));
            step();
        end
    endtask

    initial begin
        int unsigned base;

        // Reset with a non-empty FIFO
        fq.push_back(16'hA5C3);
        repeat (3) step();
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        chk("rst_valid", bus.m_valid, 1'b0);
        chk("rst_last", bus.m_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_data", bus.m_data, 4'h0);

        // Single word 0xA5C3, latency N -> N+3
        rdy  = 1'b1;
        rstn = 1'b1;
        #1;
        chk("rel_rd_en", bus.fifo_rd_en, 1'b1);
        step();
        chk("n1_rd_en", bus.fifo_rd_en, 1'b0);
        chk("n1_busy", bus.busy, 1'b1);
        chk("n1_valid", bus.m_valid, 1'b0);
        step();
        chk("n2_valid", bus.m_valid, 1'b0);
        step();
        check_word("single", 16'hA5C3);
        chk("single_idle_valid", bus.m_valid, 1'b0);
        chk("single_idle_busy", bus.busy, 1'b0);

        // Backpressure on 0x1234 after beat 2
        fq.push_back(16'h1234);
        wait_valid("bp_wait");
        chk("bp_b0", bus.m_data, beat(16'h1234, 0));
        step();
        chk("bp_b1", bus.m_data, beat(16'h1234, 1));
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", bus.m_valid, 1'b1);
            chk("bp_hold_data", bus.m_data, beat(16'h1234, 2));
            chk("bp_hold_last", bus.m_last, 1'b0);
            step();
        end
        rdy = 1'b1;
        chk("bp_b2", bus.m_data, beat(16'h1234, 2));
        step();
        chk("bp_b3", bus.m_data, beat(16'h1234, 3));
        chk("bp_b3_last", bus.m_last, 1'b1);
        step();
        chk("bp_done", bus.m_valid, 1'b0);

        // Streaming eight words, no gaps after the first beat
        repeat (3) step();
        base = rd_count;
        for (int w = 0; w < 8; w++) fq.push_back(16'h1000 + 16'(w));
        wait_valid("str_wait");
        for (int w = 0; w < 8; w++) check_word("str", 16'h1000 + 16'(w));
        repeat (4) step();
        chk("str_idle", bus.m_valid, 1'b0);
        chk("str_rd_count", rd_count - base, 8);
        chk("str_rd_empty", rd_while_empty, 0);

        // Empty FIFO
        for (int i = 0; i < 20; i++) begin
            chk("empty_rd_en", bus.fifo_rd_en, 1'b0);
            chk("empty_valid", bus.m_valid, 1'b0);
            step();
        end

        // Reset during beat 1 of 0xBEEF with 0x1111 prefetched
        fq.push_back(16'hBEEF);
        fq.push_back(16'h1111);
        wait_valid("mr_wait");
        chk("mr_b0", bus.m_data, beat(16'hBEEF, 0));
        step();
        chk("mr_b1", bus.m_data, beat(16'hBEEF, 1));
        chk("mr_pf", dut.pf_valid, 1'b1);
        #2;
        rstn = 1'b0;
        fq.delete();
        #1;
        chk("mr_valid", bus.m_valid, 1'b0);
        chk("mr_last", bus.m_last, 1'b0);
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_data", bus.m_data, 4'h0);
        chk("mr_rd_en", bus.fifo_rd_en, 1'b0);
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("mr_post_valid", bus.m_valid, 1'b0);
        fq.push_back(16'h0F0F);
        wait_valid("mr2_wait");
        check_word("reload", 16'h0F0F);
        chk("reload_idle", bus.m_valid, 1'b0);
        chk("final_rd_empty", rd_while_empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

- Drains words from the read side of `sync_fifo` and emits each `DWIDTH`-bit word as `DWIDTH/OWIDTH` narrower beats on a valid/ready output stream.
- Sits directly downstream of `sync_fifo`: it drives the FIFO's `rd_en` and consumes `dout` and `empty`.
- A one-word prefetch register hides the FIFO read latency, so words stream back-to-back.

## Interface

Parameters:
- `DWIDTH`, 16: FIFO word width. Must be an integer multiple of `OWIDTH`.
- `OWIDTH`, 4: output beat width. `RATIO = DWIDTH/OWIDTH` must be ≥ 1.

Ports:
- `clk`, in, 1: single clock for the block.
- `rstn`, in, 1: asynchronous, active-low reset.
- `fifo_empty`, in, 1: `empty` from `sync_fifo`.
- `fifo_dout`, in, `DWIDTH`: `dout` from `sync_fifo`. Valid the cycle after an accepted read.
- `fifo_rd_en`, out, 1: read strobe to `sync_fifo`.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: downstream accepts the beat.
- `m_data`, out, `OWIDTH`: output beat.
- `m_last`, out, 1: current beat is the final beat of its word.
- `busy`, out, 1: a read is pending or the block holds a word.

## Operation

Internal state:
- `pend`: a read was issued last cycle.
- Prefetch register `pf_valid`/`pf_data`.
- Shift register `sh` with `sh_valid` and beat counter `cnt` (0..`RATIO`-1, width `clog2(RATIO)`, min 1).

Rules:
- `fifo_rd_en = rstn & !fifo_empty & !pend & (!pf_valid | pf_load)`.
  - Combinational; depends on `m_ready` through `pf_load`.
  - Never asserted while `fifo_empty` = 1.
- `pend <= fifo_rd_en`. When `pend` = 1: `pf_data <= fifo_dout`, `pf_valid <= 1`.
- `pf_load = pf_valid & (!sh_valid | (m_valid & m_ready & m_last))`.
  - On load: `sh <= pf_data`, `sh_valid <= 1`, `cnt <= 0`.
  - `pf_valid` clears unless `pend` refills it in the same cycle.
- Beat accepted (`m_valid & m_ready`) with `cnt < RATIO-1`:
  - Shift `sh` by `OWIDTH` toward the emitted end.
  - `cnt <= cnt + 1`.
- Last beat accepted with no `pf_load`: `sh_valid <= 0`.
- Output signals:
  - `m_valid = sh_valid`.
  - `m_last = sh_valid & (cnt == RATIO-1)`.
  - `busy = pend | pf_valid | sh_valid`.
- Default beat order is MSB first: `m_data = sh[DWIDTH-1 -: OWIDTH]`, shift left.
- `RATIO` = 1: every beat is the whole word, `m_last` = `m_valid`.

## Timing

- Reset (async assert, sync release):
  - `pend`, `pf_valid`, `sh_valid`, `cnt` = 0.
  - `sh` and `pf_data` = 0.
  - Outputs `m_valid`, `m_last`, `m_data`, `busy` = 0.
  - `fifo_rd_en` = 0 while `rstn` is low.
- Latency: `fifo_rd_en` high in cycle N → `pend` in N+1 → `pf_valid` in N+2 → `m_valid` and first beat in N+3.
- Sustained throughput with `m_ready` = 1 and the FIFO non-empty: one word per `max(RATIO,2)` cycles. For `RATIO` ≥ 2 there are no gaps between beats.
- Handshake:
  - Once `m_valid` rises, it stays high, and `m_data`/`m_last` stay stable, until `m_valid & m_ready`.
  - `m_ready` may toggle freely; `m_ready` high while `m_valid` is low has no effect.
- At most one word in flight plus one prefetched plus one shifting. The FIFO is never over-read.
- Reset mid-word: the partially sent word and any prefetched or pending word are discarded. The FIFO side is unaffected because it resets on the same `rstn`.

## Configuration

- `SER_LSB_FIRST_EN`
  - Defined: beats are emitted LSB first. `m_data = sh[OWIDTH-1:0]`, shift right.
  - Undefined (default): MSB first, as above.
  - Latency, handshake and `m_last` are identical in both builds.

## Test plan

- Reset: hold `rstn` = 0 with `fifo_empty` = 0 → `fifo_rd_en`, `m_valid`, `m_last`, `busy`, `m_data` all 0. After release, the first `fifo_rd_en` appears on the next cycle.
- Single word, `DWIDTH`=16, `OWIDTH`=4, FIFO holds 0xA5C3, `m_ready` = 1:
  - `m_valid` rises 3 cycles after `fifo_rd_en`.
  - Beats 0xA, 0x5, 0xC, 0x3, with `m_last` only on 0x3.
  - `busy` falls after the last beat.
  - With `SER_LSB_FIRST_EN` defined: beats 0x3, 0xC, 0x5, 0xA.
- Backpressure: drop `m_ready` for 5 cycles after beat 2 of 0x1234 → `m_data` holds 0x3 and `m_valid` stays high. Stream resumes with 0x3, 0x4; no beat lost or duplicated.
- Streaming: push 8 words 0x1000..0x1007 and hold `m_ready` = 1 → 32 contiguous beats in order, with no idle cycle after the first beat. `fifo_rd_en` is never high while `fifo_empty` = 1 and is asserted exactly 8 times.
- Empty FIFO: `fifo_empty` = 1 for 20 cycles → `fifo_rd_en` = 0 and `m_valid` = 0 throughout.
- Reset mid-operation: assert `rstn` = 0 during beat 1 of 0xBEEF with a second word prefetched → outputs clear immediately (asynchronously). After reload of 0x0F0F, beats are exactly 0x0, 0xF, 0x0, 0xF.
